mu0_control: RTL

- Control unit for the MU0 16-bit CPU: two-phase fetch/execute state machine plus a halt state.
- Drives the select lines of the datapath 16-bit 2:1 muxes (X, Y and address muxes), the register enables, the ALU function and the memory strobes.
- Takes the opcode from IR[15:12] and the accumulator N/Z flags.
- Sits directly upstream of the datapath muxes, registers and ALU.

---
 rtl/mu0_pkg.sv | 94 +++++++++
 rtl/mu0_exec_decode.sv | 60 ++++++
 rtl/mu0_control.sv | 95 +++++++++
 3 files changed

// File: rtl/mu0_pkg.sv
// ---------------------------------------------------------------------------
// mu0_pkg
// Shared definitions for the MU0 control unit: opcodes, ALU function codes,
// state encodings, datapath mux select values and the control-word struct
// that the FSM and the EXECUTE decoder exchange.
// ---------------------------------------------------------------------------
package mu0_pkg;

    // Opcodes carried in IR[15:12]
    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JGE = 4'd5;
    localparam logic [3:0] OP_JNE = 4'd6;
    localparam logic [3:0] OP_STP = 4'd7;

    // ALU function codes
    localparam logic [1:0] ALU_PASSY = 2'b00;
    localparam logic [1:0] ALU_ADD   = 2'b01;
    localparam logic [1:0] ALU_INC   = 2'b10;
    localparam logic [1:0] ALU_SUB   = 2'b11;

    // Datapath mux selects
    localparam logic SEL_ACC     = 1'b0;  // X mux
    localparam logic SEL_PC      = 1'b1;  // X mux
    localparam logic SEL_DIN     = 1'b0;  // Y mux
    localparam logic SEL_IR      = 1'b1;  // Y mux
    localparam logic SEL_ADDR_PC = 1'b0;  // address mux
    localparam logic SEL_ADDR_IR = 1'b1;  // address mux

    // FSM states; encoding 2'd3 is unreachable and recovers to FETCH
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    // Everything the control unit drives except the instruction counter
    typedef struct packed {
        logic       x_sel;
        logic       y_sel;
        logic       addr_sel;
        logic [1:0] alu_func;
        logic       acc_en;
        logic       pc_en;
        logic       ir_en;
        logic       rd;
        logic       wr;
        logic       halted;
    } ctrl_t;

    localparam ctrl_t CTRL_DEFAULT = '{
        x_sel:    SEL_ACC,
        y_sel:    SEL_DIN,
        addr_sel: SEL_ADDR_PC,
        alu_func: ALU_PASSY,
        acc_en:   1'b0,
        pc_en:    1'b0,
        ir_en:    1'b0,
        rd:       1'b0,
        wr:       1'b0,
        halted:   1'b0
    };

    // FETCH: read instruction at PC into IR while PC <= PC + 1
    localparam ctrl_t CTRL_FETCH = '{
        x_sel:    SEL_PC,
        y_sel:    SEL_DIN,
        addr_sel: SEL_ADDR_PC,
        alu_func: ALU_INC,
        acc_en:   1'b0,
        pc_en:    1'b1,
        ir_en:    1'b1,
        rd:       1'b1,
        wr:       1'b0,
        halted:   1'b0
    };

    localparam ctrl_t CTRL_HALT = '{
        x_sel:    SEL_ACC,
        y_sel:    SEL_DIN,
        addr_sel: SEL_ADDR_PC,
        alu_func: ALU_PASSY,
        acc_en:   1'b0,
        pc_en:    1'b0,
        ir_en:    1'b0,
        rd:       1'b0,
        wr:       1'b0,
        halted:   1'b1
    };

endpackage

// File: rtl/mu0_exec_decode.sv
// ---------------------------------------------------------------------------
// mu0_exec_decode
// Purely combinational map from {opcode, N, Z} to the EXECUTE control word.
// Ports:
//   i_f    [3:0] opcode (IR[15:12])
//   i_n          accumulator negative flag
//   i_z          accumulator zero flag
//   o_ctrl       control word for the EXECUTE cycle
// ---------------------------------------------------------------------------
module mu0_exec_decode
    import mu0_pkg::*;
(
    input  logic [3:0] i_f,
    input  logic       i_n,
    input  logic       i_z,
    output ctrl_t      o_ctrl
);

    // Shared by JMP and the taken conditional jumps: PC <= IR[11:0]
    ctrl_t w_jump;

    always_comb begin
        w_jump          = CTRL_DEFAULT;
        w_jump.y_sel    = SEL_IR;
        w_jump.alu_func = ALU_PASSY;
        w_jump.pc_en    = 1'b1;
    end

    always_comb begin
        o_ctrl = CTRL_DEFAULT;
        case (i_f)
            OP_LDA: begin
                o_ctrl.addr_sel = SEL_ADDR_IR;
                o_ctrl.rd       = 1'b1;
                o_ctrl.y_sel    = SEL_DIN;
                o_ctrl.alu_func = ALU_PASSY;
                o_ctrl.acc_en   = 1'b1;
            end
            OP_STA: begin
                // Dout is driven from Acc by the datapath
                o_ctrl.addr_sel = SEL_ADDR_IR;
                o_ctrl.wr       = 1'b1;
            end
            OP_ADD, OP_SUB: begin
                o_ctrl.addr_sel = SEL_ADDR_IR;
                o_ctrl.rd       = 1'b1;
                o_ctrl.x_sel    = SEL_ACC;
                o_ctrl.y_sel    = SEL_DIN;
                o_ctrl.alu_func = (i_f == OP_SUB) ? ALU_SUB : ALU_ADD;
                o_ctrl.acc_en   = 1'b1;
            end
            OP_JMP: o_ctrl = w_jump;
            OP_JGE: if (!i_n) o_ctrl = w_jump;
            OP_JNE: if (!i_z) o_ctrl = w_jump;
            // STP and the undefined opcodes 8..15 leave every line idle
            default: o_ctrl = CTRL_DEFAULT;
        endcase
    end

endmodule

// File: rtl/mu0_control.sv
// ---------------------------------------------------------------------------
// mu0_control
// MU0 control unit: FETCH/EXECUTE/HALT state machine and retired-instruction
// counter. Control outputs are decoded combinationally from the state, the
// opcode and the accumulator flags (zero-latency decode).
// Ports:
//   Clk, Reset               clock (rising edge), async active-high reset
//   F [3:0], N, Z            opcode (valid in EXECUTE), Acc flags
//   XSel, YSel, AddrSel      datapath mux selects
//   ALUFunc [1:0]            ALU function
//   AccEn, PcEn, IrEn        register load enables
//   Rd, Wr                   memory strobes
//   Halted                   high while in HALT
//   InstrCount               number of completed EXECUTE cycles (wraps)
// ---------------------------------------------------------------------------
module mu0_control
    import mu0_pkg::*;
#(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [3:0]             F,
    input  logic                   N,
    input  logic                   Z,
    output logic                   XSel,
    output logic                   YSel,
    output logic                   AddrSel,
    output logic [1:0]             ALUFunc,
    output logic                   AccEn,
    output logic                   PcEn,
    output logic                   IrEn,
    output logic                   Rd,
    output logic                   Wr,
    output logic                   Halted,
    output logic [COUNT_WIDTH-1:0] InstrCount
);

    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_e                 r_state;
    logic [COUNT_WIDTH-1:0] r_instr_count;
    ctrl_t                  w_exec_ctrl;
    ctrl_t                  w_ctrl;

    mu0_exec_decode u_exec_decode (
        .i_f    (F),
        .i_n    (N),
        .i_z    (Z),
        .o_ctrl (w_exec_ctrl)
    );

    // State register and instruction counter; the counter advances on every
    // edge that leaves EXECUTE, whatever the opcode was.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state       <= ST_FETCH;
            r_instr_count <= '0;
        end else begin
            case (r_state)
                ST_FETCH: r_state <= ST_EXEC;
                ST_EXEC: begin
                    r_instr_count <= r_instr_count + COUNT_ONE;
                    r_state       <= (F == OP_STP) ? ST_HALT : ST_FETCH;
                end
                ST_HALT:  r_state <= ST_HALT;
                default:  r_state <= ST_FETCH;
            endcase
        end
    end

    // Opcode is only consulted in EXECUTE, so F may be garbage in FETCH.
    always_comb begin
        w_ctrl = CTRL_DEFAULT;
        case (r_state)
            ST_FETCH: w_ctrl = CTRL_FETCH;
            ST_EXEC:  w_ctrl = w_exec_ctrl;
            ST_HALT:  w_ctrl = CTRL_HALT;
            default:  w_ctrl = CTRL_DEFAULT;
        endcase
    end

    assign XSel       = w_ctrl.x_sel;
    assign YSel       = w_ctrl.y_sel;
    assign AddrSel    = w_ctrl.addr_sel;
    assign ALUFunc    = w_ctrl.alu_func;
    assign AccEn      = w_ctrl.acc_en;
    assign PcEn       = w_ctrl.pc_en;
    assign IrEn       = w_ctrl.ir_en;
    assign Rd         = w_ctrl.rd;
    assign Wr         = w_ctrl.wr;
    assign Halted     = w_ctrl.halted;
    assign InstrCount = r_instr_count;

endmodule
